// File: rtl/dense_argmax_classifier.sv
// Argmax over a captured class-score vector: one comparison per cycle, reporting
// the winning index, its score and the margin over the runner-up.
module dense_argmax_classifier #(
    parameter int DATA_W      = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] in_vec [NUM_CLASSES],
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         class_idx,
    output logic signed [DATA_W-1:0] max_val,
    output logic [DATA_W:0]          margin
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic [0:0]               state_r;
    logic [IDX_W-1:0]         cnt_r;
    logic signed [DATA_W-1:0] buf_r [NUM_CLASSES];
    logic signed [DATA_W-1:0] max_r;
    logic signed [DATA_W-1:0] second_r;
    logic [IDX_W-1:0]         idx_r;

    logic signed [DATA_W-1:0] elem_s;
    logic signed [DATA_W-1:0] max_nxt_s;
    logic signed [DATA_W-1:0] second_nxt_s;
    logic [IDX_W-1:0]         idx_nxt_s;
    logic [DATA_W:0]          margin_s;

    // Running max/second update for the element under the scan pointer.
    always_comb begin
        elem_s       = buf_r[cnt_r];
        max_nxt_s    = max_r;
        second_nxt_s = second_r;
        idx_nxt_s    = idx_r;
        if (elem_s > max_r) begin
            second_nxt_s = max_r;
            max_nxt_s    = elem_s;
            idx_nxt_s    = cnt_r;
        end else if (elem_s > second_r) begin
            // An equal-to-max score lands here, which is what makes a tie give margin 0.
            second_nxt_s = elem_s;
        end else begin
            second_nxt_s = second_r;
        end
        margin_s = {max_nxt_s[DATA_W-1], max_nxt_s} - {second_nxt_s[DATA_W-1], second_nxt_s};
    end

    // Score buffer; loaded only when a start is accepted, so no reset is needed.
    always_ff @(posedge clk) begin
        if ((state_r == ST_IDLE) && start) begin
            buf_r <= in_vec;
        end
    end

    // Control FSM, running values and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            max_r     <= MOST_NEG;
            second_r  <= MOST_NEG;
            idx_r     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            class_idx <= '0;
            max_val   <= '0;
            margin    <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        max_r    <= MOST_NEG;
                        second_r <= MOST_NEG;
                        idx_r    <= '0;
                        cnt_r    <= '0;
                        busy     <= 1'b1;
                        state_r  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    max_r    <= max_nxt_s;
                    second_r <= second_nxt_s;
                    idx_r    <= idx_nxt_s;
                    cnt_r    <= cnt_r + IDX_W'(1);
                    if (cnt_r == LAST_IDX) begin
                        class_idx <= idx_nxt_s;
                        max_val   <= max_nxt_s;
                        margin    <= margin_s;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_argmax_classifier.sv
// Directed-vector bench for dense_argmax_classifier: table of score vectors with
// hand-computed results, plus sequences for reset abort and back-to-back runs.
module tb_dense_argmax_classifier;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [15:0] in_vec [10];
    logic               busy;
    logic               done;
    logic [3:0]         class_idx;
    logic [15:0]        max_val;
    logic [16:0]        margin;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [9:0][15:0] v;
        logic [3:0]       idx;
        logic [15:0]      maxv;
        logic [16:0]      margin;
    } vec_t;

    vec_t tbl [6];

    dense_argmax_classifier #(.DATA_W(16), .NUM_CLASSES(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_vec    (in_vec),
        .busy      (busy),
        .done      (done),
        .class_idx (class_idx),
        .max_val   (max_val),
        .margin    (margin)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0][15:0] mk(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6, input int a7, input int a8,
                                            input int a9);
        logic [9:0][15:0] r;
        r[0] = a0[15:0]; r[1] = a1[15:0]; r[2] = a2[15:0]; r[3] = a3[15:0];
        r[4] = a4[15:0]; r[5] = a5[15:0]; r[6] = a6[15:0]; r[7] = a7[15:0];
        r[8] = a8[15:0]; r[9] = a9[15:0];
        return r;
    endfunction

    task automatic load_vec(input logic [9:0][15:0] v);
        for (int i = 0; i < 10; i++) in_vec[i] = v[i];
    endtask

    task automatic scramble_vec();
        for (int i = 0; i < 10; i++) in_vec[i] = 16'($urandom);
    endtask

    // Waits (bounded) for done; returns cycles waited and how many samples saw busy.
    task automatic wait_done(output int cyc, output int busy_seen);
        cyc = 0;
        busy_seen = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (busy) busy_seen++;
        end while (!done && cyc < 40);
    endtask

    task automatic run_vec(input vec_t t, input string nm);
        int cyc;
        int bsy;
        load_vec(t.v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_vec();
        check({nm, "_busy_start"}, 32'(busy), 32'd1);
        wait_done(cyc, bsy);
        check({nm, "_latency"}, 32'(cyc), 32'd10);
        check({nm, "_busy_cycles"}, 32'(bsy + 1), 32'd10);
        check({nm, "_busy_at_done"}, 32'(busy), 32'd0);
        check({nm, "_idx"}, 32'(class_idx), 32'(t.idx));
        check({nm, "_max"}, 32'(max_val), 32'(t.maxv));
        check({nm, "_margin"}, 32'(margin), 32'(t.margin));
        @(posedge clk); #1;
        check({nm, "_done_single"}, 32'(done), 32'd0);
        check({nm, "_idx_hold"}, 32'(class_idx), 32'(t.idx));
    endtask

    initial begin
        int cyc;
        int bsy;
        int done_seen;

        tbl[0] = '{v: mk(5, -3, 120, 7, 0, 90, -200, 15, 33, 1),
                   idx: 4'd2, maxv: 16'd120, margin: 17'd30};
        tbl[1] = '{v: mk(0, 0, 0, 500, 0, 0, 0, 0, 500, 0),
                   idx: 4'd3, maxv: 16'd500, margin: 17'd0};
        tbl[2] = '{v: mk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 32767),
                   idx: 4'd9, maxv: 16'd32767, margin: 17'd65535};
        tbl[3] = '{v: mk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768),
                   idx: 4'd0, maxv: 16'h8000, margin: 17'd0};
        tbl[4] = '{v: mk(-10, -4, -9, -4, -50, -60, -70, -80, -90, -100),
                   idx: 4'd1, maxv: 16'hFFFC, margin: 17'd0};
        tbl[5] = '{v: mk(1000, 1, 2, 3, 4, 5, 6, 7, 8, 999),
                   idx: 4'd0, maxv: 16'd1000, margin: 17'd1};

        rst = 1'b1;
        start = 1'b0;
        scramble_vec();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_idx", 32'(class_idx), 32'd0);
        check("reset_max", 32'(max_val), 32'd0);
        check("reset_margin", 32'(margin), 32'd0);

        for (int n = 0; n < 6; n++) begin
            run_vec(tbl[n], $sformatf("vec%0d", n));
        end

        // Reset mid-scan: outputs currently hold tbl[5]'s result and must clear.
        load_vec(tbl[0].v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_idx", 32'(class_idx), 32'd0);
        check("abort_max", 32'(max_val), 32'd0);
        check("abort_margin", 32'(margin), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        run_vec(tbl[4], "after_abort");

        // Back-to-back: second start in the done cycle, plus a start injected mid-scan.
        load_vec(tbl[0].v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, bsy);
        check("b2b_first_latency", 32'(cyc), 32'd10);
        check("b2b_first_idx", 32'(class_idx), 32'd2);
        load_vec(tbl[5].v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_vec();
        check("b2b_second_busy", 32'(busy), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        load_vec(mk(0, 0, 0, 0, 0, 2000, 0, 0, 0, 0));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignored_start_busy", 32'(busy), 32'd1);
        wait_done(cyc, bsy);
        check("b2b_second_latency", 32'(cyc), 32'd6);
        check("b2b_second_idx", 32'(class_idx), 32'd0);
        check("b2b_second_max", 32'(max_val), 32'd1000);
        check("b2b_second_margin", 32'(margin), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_ignored", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
